simd_result_packer: RTL and testbench
=====================================

# simd_result_packer

Writeback-side counterpart of the SIMD operand organizer. It accepts raw lane results from the SIMD execute unit and undoes the horizontal-operation lane pairing. It then merges masked-off lanes with the old destination value and delivers the packed result to writeback through a 2-entry valid/ready buffer. It sits between the SIMD ALU output and the register-file write port.

## Interface
- DATA_W, `SIMD_DATA_WIDTH (64): result width; lane slicing below is defined for 64.
- TAG_W, 5: width of the destination-register tag carried with each result.
- DEPTH, 2: output buffer entries; only 2 is supported.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  a result is presented.
- in_ready  out  1  the block can take a result this cycle.
- in_result  in  DATA_W  raw lane-wise ALU result.
- in_rd_old  in  DATA_W  current destination register value.
- in_tag  in  TAG_W  destination register index.
- in_mask  in  4  lane enables.
- in_mask_ena  in  1  masking active.
- in_simd_ena  in  1  SIMD instruction.
- in_funct3  in  `FUNCT3_WIDTH  bit 2 = horizontal op; bits 1:0 = element size (`SIMD16 / `SIMD32).
- out_valid  out  1  packed result available.
- out_ready  in  1  writeback accepts.
- out_data  out  DATA_W  packed, merged result.
- out_tag  out  TAG_W  tag of out_data.

## Operation
- **Transfer:** an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- **Stage 1 (combinational, on input) — horizontal unpack.** Applies when in_simd_ena && in_funct3[2]. Let r = in_result.
  - `SIMD16: p = {r[63:48], r[31:16], r[47:32], r[15:0]}. Results derived from rs1 go to the upper half, results derived from rs2 go to the lower half.
  - `SIMD32: p = r.
  - Any other size: p = r.
  - Not horizontal, or not SIMD: p = r.
- **Stage 2 (combinational) — mask merge.** Applies when in_simd_ena && in_mask_ena.
  - `SIMD16: 16-bit lane i takes p if in_mask[i], else in_rd_old lane i (i = 0..3).
  - `SIMD32: 32-bit lane i takes p if in_mask[i], else in_rd_old lane i (i = 0..1). in_mask[3:2] are ignored.
  - Otherwise the merged value is p unchanged.
- **Buffering:** the merged value and in_tag are written into a 2-entry FIFO on each input transfer.
  - out_data and out_tag are driven from the head entry.
  - out_valid = FIFO not empty.
  - in_ready = FIFO not full, so the input side may fill while out_ready is low.
- **FIFO state:** occupancy count 0..2, with 1-bit write and read pointers that wrap 1→0.
  - Push and pop in the same cycle at count 1 or 2: count is unchanged, both pointers advance.
  - At count 0 the block never bypasses. Input is visible at the output only from the next cycle.
  - At count 2, in_ready = 0. A pop in that cycle does not enable a same-cycle push (no combinational ready path from out_ready).
- **Flush:** when flush = 1 on a clock edge, count and both pointers go to 0.
  - Any input presented in that cycle is dropped.
  - in_ready is still driven as the non-full value, and the dropped push is not counted.
- **Reset:** count = 0, pointers = 0, out_valid = 0, in_ready = 1.
  - out_data = 0 and out_tag = 0. Storage is reset so that out_data is defined.
  - Reset asserted mid-transfer discards all entries immediately (asynchronous).

## Timing
- Latency: an input accepted at edge N appears on out_data with out_valid = 1 after edge N, i.e. in cycle N+1.
- Throughput: one result per cycle while out_ready = 1.
- in_ready depends only on registered state. out_valid, out_data and out_tag are register or mux outputs; there is no path from in_* to out_*.
- out_data and out_tag stay stable while out_valid && !out_ready.
- Stages 1 and 2 must fit in the single input cycle, before the FIFO write.

## Test plan
- **Horizontal SIMD16 unpack:** simd=1, funct3 = {1,`SIMD16}, mask_ena=0, result 0x4444_3333_2222_1111 → out_data 0x4444_2222_3333_1111 one cycle later, out_tag equal to the input tag.
- **Masked SIMD16 merge:** simd=1, funct3 = {0,`SIMD16}, mask_ena=1, mask 4'b0101, result 0xAAAA_BBBB_CCCC_DDDD, rd_old 0x1111_2222_3333_4444 → out_data 0x1111_BBBB_3333_DDDD.
- **Masked SIMD32 merge:** mask 4'b1110, result 0xDEAD_BEEF_0123_4567, rd_old 0x0 → out_data 0xDEAD_BEEF_0000_0000 (mask[3:2] ignored).
- **Backpressure:** out_ready=0 with 3 back-to-back inputs.
  - After the second accept, in_ready=0 and the third is held.
  - Raise out_ready: outputs come out in order 1, 2, 3 with no loss or duplication, and in_ready returns to 1 the cycle after the first pop.
- **Simultaneous push/pop at count 1 and flush:**
  - Push/pop at count 1: count stays 1 and the data order is preserved.
  - flush with count=2 and in_valid=1: next cycle out_valid=0, in_ready=1, and the flushed input never appears.
- **Asynchronous reset mid-stream:** assert rst_n=0 between clock edges with count=2 → out_valid=0 and out_data=0 immediately; after release the first new input emerges correctly.

Source files
------------

// File: rtl/simd_result_packer.sv
// SIMD writeback packer: undoes horizontal lane pairing, merges
// masked-off lanes with the old destination, buffers in a 2-entry FIFO.
`ifndef SIMD_DATA_WIDTH
`define SIMD_DATA_WIDTH 64
`endif
`ifndef FUNCT3_WIDTH
`define FUNCT3_WIDTH 3
`endif
`ifndef SIMD16
`define SIMD16 2'b01
`endif
`ifndef SIMD32
`define SIMD32 2'b10
`endif

module simd_result_packer #(
    parameter int DATA_W = `SIMD_DATA_WIDTH,
    parameter int TAG_W  = 5,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_result,
    input  logic [DATA_W-1:0]        in_rd_old,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic [3:0]               in_mask,
    input  logic                     in_mask_ena,
    input  logic                     in_simd_ena,
    input  logic [`FUNCT3_WIDTH-1:0] in_funct3,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [TAG_W-1:0]         out_tag
);

    logic [DATA_W-1:0] unpacked;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [TAG_W-1:0]  mem_tag  [DEPTH];
    logic [1:0]        count;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              push;
    logic              pop;

    // Horizontal SIMD16 ops interleave rs1/rs2 lanes; restore rs1 high, rs2 low
    always_comb begin
        unpacked = in_result;
        if (in_simd_ena && in_funct3[2] && in_funct3[1:0] == `SIMD16)
            unpacked = {in_result[63:48], in_result[31:16],
                        in_result[47:32], in_result[15:0]};
    end

    // Disabled lanes keep the old destination value
    always_comb begin
        merged = unpacked;
        if (in_simd_ena && in_mask_ena) begin
            case (in_funct3[1:0])
                `SIMD16: begin
                    for (int i = 0; i < 4; i++)
                        if (!in_mask[i])
                            merged[16*i +: 16] = in_rd_old[16*i +: 16];
                end
                `SIMD32: begin
                    for (int i = 0; i < 2; i++)
                        if (!in_mask[i])
                            merged[32*i +: 32] = in_rd_old[32*i +: 32];
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem_data[rd_ptr];
    assign out_tag   = mem_tag[rd_ptr];
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Storage is reset so the head reads zero when empty after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_tag[i]  <= '0;
            end
        end else if (push) begin
            mem_data[wr_ptr] <= merged;
            mem_tag[wr_ptr]  <= in_tag;
        end
    end

    // Occupancy and pointer update; flush empties without clearing storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_simd_result_packer.sv
// Self-checking bench for simd_result_packer: directed cases then
// randomized traffic against a queue-based reference model.
`ifndef SIMD_DATA_WIDTH
`define SIMD_DATA_WIDTH 64
`endif
`ifndef FUNCT3_WIDTH
`define FUNCT3_WIDTH 3
`endif
`ifndef SIMD16
`define SIMD16 2'b01
`endif
`ifndef SIMD32
`define SIMD32 2'b10
`endif

module tb_simd_result_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic [63:0] in_rd_old;
    logic [4:0]  in_tag;
    logic [3:0]  in_mask;
    logic        in_mask_ena;
    logic        in_simd_ena;
    logic [2:0]  in_funct3;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_tag;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
    } entry_t;

    entry_t q[$];
    int     errors = 0;
    int     checks = 0;

    simd_result_packer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_rd_old(in_rd_old),
        .in_tag(in_tag), .in_mask(in_mask),
        .in_mask_ena(in_mask_ena), .in_simd_ena(in_simd_ena),
        .in_funct3(in_funct3), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_pack(
        input logic [63:0] res, input logic [63:0] old,
        input logic [3:0] mask, input logic mena,
        input logic simd, input logic [2:0] f3);
        int          src [4];
        logic [63:0] p;
        logic [63:0] lm;
        int          w;
        src = '{0, 2, 1, 3};
        p = res;
        if (simd && f3[2] && f3[1:0] == `SIMD16)
            for (int i = 0; i < 4; i++)
                p[16*i +: 16] = res[16*src[i] +: 16];
        w = 0;
        if (f3[1:0] == `SIMD16) w = 16;
        if (f3[1:0] == `SIMD32) w = 32;
        if (simd && mena && w != 0)
            for (int i = 0; i < 64 / w; i++)
                if (!mask[i]) begin
                    lm = ((w == 32) ? 64'hFFFF_FFFF : 64'hFFFF) << (i * w);
                    p = (p & ~lm) | (old & lm);
                end
        return p;
    endfunction

    task automatic drive(input logic v, input logic [63:0] res,
                         input logic [63:0] old, input logic [4:0] tag,
                         input logic [3:0] mask, input logic mena,
                         input logic simd, input logic [2:0] f3);
        in_valid    = v;
        in_result   = res;
        in_rd_old   = old;
        in_tag      = tag;
        in_mask     = mask;
        in_mask_ena = mena;
        in_simd_ena = simd;
        in_funct3   = f3;
    endtask

    // Check current outputs against model, clock once, update model
    task automatic cycle();
        bit     acc;
        bit     deq;
        entry_t e;
        chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        if (q.size() > 0) begin
            chk("out_data", out_data, q[0].data);
            chk("out_tag", {59'd0, out_tag}, {59'd0, q[0].tag});
        end
        acc = in_valid && (q.size() < 2);
        deq = out_ready && (q.size() > 0);
        e.data = ref_pack(in_result, in_rd_old, in_mask, in_mask_ena,
                          in_simd_ena, in_funct3);
        e.tag = in_tag;
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (deq) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_data", out_data, 64'd0);
        chk("rst_tag", {59'd0, out_tag}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // horizontal SIMD16 unpack
        drive(1, 64'h4444_3333_2222_1111, 0, 5'd7, 0, 0, 1,
              {1'b1, `SIMD16});
        cycle();
        chk("h16_valid", {63'd0, out_valid}, 64'd1);
        chk("h16_data", out_data, 64'h4444_2222_3333_1111);
        chk("h16_tag", {59'd0, out_tag}, 64'd7);
        out_ready = 1'b1;
        idle(1);

        // masked SIMD16 merge
        out_ready = 1'b0;
        drive(1, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444,
              5'd3, 4'b0101, 1, 1, {1'b0, `SIMD16});
        cycle();
        chk("m16_data", out_data, 64'h1111_BBBB_3333_DDDD);
        out_ready = 1'b1;
        idle(1);

        // masked SIMD32 merge, upper mask bits ignored
        out_ready = 1'b0;
        drive(1, 64'hDEAD_BEEF_0123_4567, 64'd0, 5'd9, 4'b1110, 1, 1,
              {1'b0, `SIMD32});
        cycle();
        chk("m32_data", out_data, 64'hDEAD_BEEF_0000_0000);
        out_ready = 1'b1;
        idle(1);

        // backpressure with three back-to-back inputs
        out_ready = 1'b0;
        drive(1, 64'h1, 0, 5'd1, 0, 0, 0, 0);
        cycle();
        drive(1, 64'h2, 0, 5'd2, 0, 0, 0, 0);
        cycle();
        chk("bp_full", {63'd0, in_ready}, 64'd0);
        drive(1, 64'h3, 0, 5'd3, 0, 0, 0, 0);
        cycle();
        out_ready = 1'b1;
        chk("bp_head", out_data, 64'h1);
        cycle();
        chk("bp_reopen", {63'd0, in_ready}, 64'd1);
        chk("bp_second", out_data, 64'h2);
        cycle();
        idle(3);

        // push/pop at count 1 keeps count and order
        out_ready = 1'b0;
        drive(1, 64'h10, 0, 5'd10, 0, 0, 0, 0);
        cycle();
        out_ready = 1'b1;
        drive(1, 64'h11, 0, 5'd11, 0, 0, 0, 0);
        cycle();
        chk("pp_valid", {63'd0, out_valid}, 64'd1);
        chk("pp_ready", {63'd0, in_ready}, 64'd1);
        chk("pp_data", out_data, 64'h11);
        idle(2);

        // flush at count 2 with an input presented
        out_ready = 1'b0;
        drive(1, 64'h20, 0, 5'd20, 0, 0, 0, 0);
        cycle();
        drive(1, 64'h21, 0, 5'd21, 0, 0, 0, 0);
        cycle();
        drive(1, 64'h22, 0, 5'd22, 0, 0, 0, 0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        idle(3);

        // asynchronous reset with two entries held
        out_ready = 1'b0;
        drive(1, 64'h30, 0, 5'd30, 0, 0, 0, 0);
        cycle();
        drive(1, 64'h31, 0, 5'd31, 0, 0, 0, 0);
        cycle();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_data", out_data, 64'd0);
        chk("ar_ready", {63'd0, in_ready}, 64'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 64'h40, 0, 5'd4, 0, 0, 0, 0);
        cycle();
        chk("ar_new", out_data, 64'h40);
        out_ready = 1'b1;
        idle(2);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0,
                  {$urandom, $urandom}, {$urandom, $urandom},
                  5'($urandom), 4'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 3'($urandom));
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 29) == 0;
            cycle();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
